ball_grid_scheduler: RTL and testbench

- Owns the single-port grid-count RAM that backs ball detection.
- Time-shares the RAM between two users:
  - pixel-hit accumulation during active video;
  - a combined max-scan/clear pass during vertical blanking.
- Publishes the winning 16x16 block as the ball position once per frame.
- Sits between the per-pixel colour classifier (supplies hit flag and grid coordinates) and the overlay/tracking logic.

---
 rtl/ball_pkg.sv | 21 ++
 rtl/ball_run_accum.sv | 78 +++++++
 rtl/ball_grid_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ball_grid_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared grid geometry, state encodings and saturating arithmetic
// for the ball grid scheduler.
package ball_pkg;

    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int CNT_W  = 9;
    localparam int ADDR_W = 11;
    localparam int CELLS  = ROWS * COLS;

    typedef enum logic [2:0] {INIT, ACCUM, DRAIN, SCAN, PUBLISH} state_t;
    typedef enum logic [1:0] {F_IDLE, F_READ, F_WRITE} flush_t;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ball_run_accum.sv
// Run-length hit accumulator: collapses consecutive hits in one grid cell
// into a single read-modify-write of the count RAM.
module ball_run_accum
    import ball_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hit_en,
    input  logic              drain,
    input  logic              pix_valid,
    input  logic              pix_hit,
    input  logic [5:0]        pix_xg,
    input  logic [4:0]        pix_yg,
    input  logic [CNT_W-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [CNT_W-1:0]  mem_wdata,
    output logic              busy,
    output logic              overrun
);

    flush_t            ph;
    logic              hit_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] run_addr;
    logic [ADDR_W-1:0] flush_addr;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              can_flush;

    // The flush slot frees up during the write cycle, so a new flush may start there.
    assign can_flush = (ph != F_READ);
    assign mem_addr  = flush_addr;
    assign mem_we    = (ph == F_WRITE);
    assign mem_wdata = mem_we ? sat_add(mem_rdata, flush_cnt) : '0;
    assign busy      = hit_q | (run_cnt != '0) | (ph != F_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph         <= F_IDLE;
            hit_q      <= 1'b0;
            addr_q     <= '0;
            run_addr   <= '0;
            flush_addr <= '0;
            run_cnt    <= '0;
            flush_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            hit_q   <= hit_en & pix_valid & pix_hit;
            addr_q  <= ADDR_W'(int'(pix_yg) * COLS + int'(pix_xg));
            overrun <= 1'b0;
            ph      <= (ph == F_READ) ? F_WRITE : F_IDLE;
            if (hit_q) begin
                if (run_cnt != '0 && addr_q == run_addr) begin
                    run_cnt <= sat_add(run_cnt, CNT_W'(1));
                end else if (run_cnt == '0) begin
                    run_addr <= addr_q;
                    run_cnt  <= CNT_W'(1);
                end else if (!can_flush) begin
                    // Flush slot still reading: this hit is lost, the old run stays.
                    overrun <= 1'b1;
                end else begin
                    flush_addr <= run_addr;
                    flush_cnt  <= run_cnt;
                    ph         <= F_READ;
                    run_addr   <= addr_q;
                    run_cnt    <= CNT_W'(1);
                end
            end else if (drain && run_cnt != '0 && can_flush) begin
                flush_addr <= run_addr;
                flush_cnt  <= run_cnt;
                ph         <= F_READ;
                run_cnt    <= '0;
            end
        end
    end

endmodule

// File: rtl/ball_grid_scheduler.sv
// Time-shares the grid-count RAM between hit accumulation in active video and a
// combined max-scan/clear pass in vertical blanking; publishes the ball cell per frame.
module ball_grid_scheduler
    import ball_pkg::*;
#(
    parameter int THRESH = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              VGA_VS,
    input  logic              PIX_VALID,
    input  logic              PIX_HIT,
    input  logic [5:0]        PIX_XG,
    input  logic [4:0]        PIX_YG,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [CNT_W-1:0]  MEM_WDATA,
    input  logic [CNT_W-1:0]  MEM_RDATA,
    output logic [5:0]        BALL_X,
    output logic [4:0]        BALL_Y,
    output logic              BALL_VALID,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output logic              OVERRUN
);

    localparam logic [CNT_W-1:0]  THR       = CNT_W'(THRESH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [5:0]        X_LAST    = 6'(COLS - 1);

    state_t            state;
    logic              vs_q, vs_rise, hit;
    logic [ADDR_W-1:0] cnt, t_addr;
    logic              t_we, own_top, odd, scan_done, cmp_valid, found, valid_q;
    logic [5:0]        sx, cmp_x, best_x;
    logic [4:0]        sy, cmp_y, best_y;
    logic [CNT_W-1:0]  best_cnt;
    logic [ADDR_W-1:0] a_addr;
    logic              a_we, a_busy, a_overrun;
    logic [CNT_W-1:0]  a_wdata;

    assign vs_rise    = VGA_VS & ~vs_q;
    assign hit        = PIX_VALID & PIX_HIT & ENABLE;
    // own_top tracks what is on the bus this cycle, not the FSM state.
    assign MEM_ADDR   = own_top ? t_addr : a_addr;
    assign MEM_WE     = own_top ? t_we : a_we;
    assign MEM_WDATA  = own_top ? '0 : a_wdata;
    assign BALL_VALID = valid_q & ENABLE;

    ball_run_accum u_accum (
        .clk       (CLK),
        .rst_n     (RST_N),
        .hit_en    ((state == ACCUM) & ENABLE),
        .drain     (state == DRAIN),
        .pix_valid (PIX_VALID),
        .pix_hit   (PIX_HIT),
        .pix_xg    (PIX_XG),
        .pix_yg    (PIX_YG),
        .mem_rdata (MEM_RDATA),
        .mem_addr  (a_addr),
        .mem_we    (a_we),
        .mem_wdata (a_wdata),
        .busy      (a_busy),
        .overrun   (a_overrun)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= INIT;
            vs_q       <= 1'b0;
            cnt        <= '0;
            t_addr     <= '0;
            t_we       <= 1'b0;
            own_top    <= 1'b0;
            odd        <= 1'b0;
            scan_done  <= 1'b0;
            cmp_valid  <= 1'b0;
            sx         <= '0;
            sy         <= '0;
            cmp_x      <= '0;
            cmp_y      <= '0;
            best_x     <= '0;
            best_y     <= '0;
            best_cnt   <= '0;
            found      <= 1'b0;
            valid_q    <= 1'b0;
            BALL_X     <= '0;
            BALL_Y     <= '0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            vs_q       <= VGA_VS;
            FRAME_DONE <= 1'b0;
            t_we       <= 1'b0;
            own_top    <= 1'b0;
            if (a_overrun || (hit && (state == DRAIN || state == SCAN))) OVERRUN <= 1'b1;
            case (state)
                INIT: begin
                    t_addr  <= cnt;
                    t_we    <= 1'b1;
                    own_top <= 1'b1;
                    BUSY    <= 1'b1;
                    if (cnt == LAST_ADDR) begin
                        cnt   <= '0;
                        state <= ACCUM;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ACCUM: begin
                    BUSY <= vs_rise;
                    if (vs_rise) state <= DRAIN;
                end
                DRAIN: begin
                    if (!a_busy) state <= SCAN;
                end
                SCAN: begin
                    // Read data for the previous cell is on MEM_RDATA while its clear is on the bus.
                    cmp_valid <= 1'b0;
                    if (cmp_valid && MEM_RDATA > THR && MEM_RDATA > best_cnt) begin
                        found    <= 1'b1;
                        best_cnt <= MEM_RDATA;
                        best_x   <= cmp_x;
                        best_y   <= cmp_y;
                    end
                    if (scan_done) begin
                        scan_done <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= PUBLISH;
                    end else begin
                        t_addr  <= cnt;
                        own_top <= 1'b1;
                        t_we    <= odd;
                        odd     <= ~odd;
                        if (odd) begin
                            cmp_valid <= 1'b1;
                            cmp_x     <= sx;
                            cmp_y     <= sy;
                            if (cnt == LAST_ADDR) begin
                                cnt       <= '0;
                                sx        <= '0;
                                sy        <= '0;
                                scan_done <= 1'b1;
                            end else begin
                                cnt <= cnt + ADDR_W'(1);
                                if (sx == X_LAST) begin
                                    sx <= '0;
                                    sy <= sy + 5'd1;
                                end else begin
                                    sx <= sx + 6'd1;
                                end
                            end
                        end
                    end
                end
                PUBLISH: begin
                    if (found) begin
                        BALL_X <= best_x;
                        BALL_Y <= best_y;
                    end
                    valid_q    <= found & ENABLE;
                    FRAME_DONE <= 1'b1;
                    found      <= 1'b0;
                    best_cnt   <= '0;
                    best_x     <= '0;
                    best_y     <= '0;
                    state      <= ACCUM;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_grid_scheduler.sv
// Scoreboard bench for ball_grid_scheduler with a behavioural single-port RAM.
module tb_ball_grid_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, enable, vga_vs, pix_valid, pix_hit;
    logic [5:0]  pix_xg;
    logic [4:0]  pix_yg;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [8:0]  mem_wdata, mem_rdata;
    logic [5:0]  ball_x;
    logic [4:0]  ball_y;
    logic        ball_valid, frame_done, busy, overrun;

    typedef struct {int x; int y; int v;} exp_t;
    exp_t sb[$];
    exp_t e;

    int n_pass = 0;
    int n_total = 0;

    logic [8:0]  ram [0:2047];
    logic        filled = 1'b0;
    int          watch_addr = 125;
    logic [8:0]  watch_val;

    always #5 clk = ~clk;

    ball_grid_scheduler #(.THRESH(8)) dut (
        .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .VGA_VS(vga_vs),
        .PIX_VALID(pix_valid), .PIX_HIT(pix_hit), .PIX_XG(pix_xg), .PIX_YG(pix_yg),
        .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
        .BALL_X(ball_x), .BALL_Y(ball_y), .BALL_VALID(ball_valid),
        .FRAME_DONE(frame_done), .BUSY(busy), .OVERRUN(overrun)
    );

    // RAM prefilled with junk so that INIT clearing is observable.
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 9'h1AB;
            filled <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_we && int'(mem_addr) == watch_addr) watch_val <= ram[mem_addr];
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ball_x", int'(ball_x), e.x);
                check("ball_y", int'(ball_y), e.y);
                check("ball_valid", int'(ball_valid), e.v);
            end
        end
    end

    function automatic int nonzero_cells();
        int n = 0;
        for (int i = 0; i < 1200; i++) if (ram[i] != 9'd0) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hits(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = 1'b1; pix_hit = 1'b1; pix_xg = 6'(x); pix_yg = 5'(y);
        end
        @(negedge clk);
        pix_valid = 1'b0; pix_hit = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk); vga_vs = 1'b1;
        idle(3);
        vga_vs = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin @(negedge clk); n++; end while (!frame_done && n < 6000);
        if (!frame_done) check("frame_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        if (!busy) check("busy_timeout", 0, 1);
    endtask

    task automatic frame(input int x, input int y, input int v);
        sb.push_back('{x, y, v});
        vs_pulse();
        wait_frame();
    endtask

    task automatic check_reset_outputs();
        check("reset_ctrl", int'({mem_we, busy, ball_valid, frame_done, overrun}), 0);
        check("reset_ball_xy", int'({ball_x, ball_y}), 0);
        check("reset_mem_bus", int'({mem_addr, mem_wdata}), 0);
    endtask

    // A VS pulse inside INIT must not start a frame.
    task automatic release_and_init();
        int n = 0;
        int guard = 0;
        @(negedge clk); rst_n = 1'b1;
        while (guard < 3000) begin
            @(negedge clk); guard++;
            if (guard == 500) vga_vs = 1'b1;
            if (guard == 504) vga_vs = 1'b0;
            if (busy) n++;
            else if (n > 0) break;
        end
        check("init_busy_cycles", n, 1200);
        check("init_cells_zero", nonzero_cells(), 0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; vga_vs = 1'b0;
        pix_valid = 1'b0; pix_hit = 1'b0; pix_xg = '0; pix_yg = '0;
        idle(3);
        check_reset_outputs();
        release_and_init();
        check("accum_idle_outputs", int'({ball_valid, frame_done, busy, overrun}), 0);

        hits(5, 3, 20); idle(5);
        frame(5, 3, 1);
        check("ram125_before_clear", int'(watch_val), 20);
        check("valid_enable_hi", int'(ball_valid), 1);
        enable = 1'b0; #1;
        check("valid_forced_low", int'(ball_valid), 0);
        enable = 1'b1;

        hits(7, 7, 8); frame(5, 3, 0);
        hits(7, 7, 9); frame(7, 7, 1);
        hits(2, 1, 30); hits(10, 0, 30); frame(10, 0, 1);

        watch_addr = 620;
        for (int b = 0; b < 6; b++) begin
            hits(20, 15, 100); idle(20);
            hits(39, 29, 5); idle(20);
        end
        frame(20, 15, 1);
        check("saturated_count", int'(watch_val), 511);
        frame(20, 15, 0);
        check("cells_clear", nonzero_cells(), 0);

        watch_addr = 41;
        enable = 1'b0;
        hits(1, 1, 20);
        frame(20, 15, 0);
        enable = 1'b1;
        check("disabled_hits_ignored", int'(watch_val), 0);

        check("overrun_initially_clear", int'(overrun), 0);
        sb.push_back('{20, 15, 0});
        vs_pulse(); wait_busy(); idle(100);
        hits(0, 0, 1);
        check("overrun_set", int'(overrun), 1);
        wait_frame();
        check("overrun_sticky", int'(overrun), 1);

        hits(3, 3, 20);
        vs_pulse(); wait_busy(); idle(60);
        check("ram123_flushed", int'(ram[123]), 20);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        idle(2);
        release_and_init();

        idle(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
